// File: rtl/coin_change_dispenser.sv
// Change-return controller: computes overpayment against a fixed price and pays it out
// greedily (20, 10, 5) over a 4-phase strobe/acknowledge handshake, one coin at a time.
module coin_change_dispenser #(
  parameter int unsigned PRICE       = 45,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req_i,
  input  logic [5:0] credit_i,
  input  logic       eject_ack_i,
  output logic       eject20_o,
  output logic       eject10_o,
  output logic       eject5_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       fault_o,
  output logic [2:0] coins_out_o
);

  localparam logic [5:0] PriceW    = 6'(PRICE);
  localparam logic [5:0] MaxCredit = 6'd60;
  localparam logic [7:0] TimeoutW  = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWaitHi,
    StWaitLo,
    StDone,
    StFault
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [5:0] remaining_q, remaining_d;
  logic [2:0] coin_q, coin_d;  // one-hot {20, 10, 5}
  logic [7:0] timer_q, timer_d;
  logic [2:0] coins_q, coins_d;
  logic       err_pend_q, err_pend_d;

  logic [2:0] strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       fault_q, fault_d;

  logic [5:0] coin_val;
  logic       credit_bad;

  always_comb begin
    coin_val = 6'd5;
    unique case (coin_q)
      3'b100:  coin_val = 6'd20;
      3'b010:  coin_val = 6'd10;
      default: coin_val = 6'd5;
    endcase
  end

  assign credit_bad = (credit_q < PriceW) || ((credit_q % 6'd5) != 6'd0) ||
                      (credit_q > MaxCredit);

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    timer_d     = timer_q;
    coins_d     = coins_q;
    err_pend_d  = err_pend_q;

    unique case (state_q)
      StIdle: begin
        if (vend_req_i) begin
          credit_d   = credit_i;
          coins_d    = 3'd0;
          err_pend_d = 1'b0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        if (credit_bad) begin
          err_pend_d = 1'b1;
          state_d    = StDone;
        end else begin
          remaining_d = credit_q - PriceW;
          state_d     = (credit_q == PriceW) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (remaining_q >= 6'd20) begin
          coin_d = 3'b100;
        end else if (remaining_q >= 6'd10) begin
          coin_d = 3'b010;
        end else begin
          coin_d = 3'b001;
        end
        timer_d = 8'd0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (eject_ack_i) begin
          remaining_d = remaining_q - coin_val;
          coins_d     = (coins_q == 3'd7) ? 3'd7 : coins_q + 3'd1;
          timer_d     = 8'd0;
          state_d     = StWaitLo;
        end else if (timer_q == TimeoutW) begin
          state_d = StFault;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StWaitLo: begin
        if (!eject_ack_i) begin
          state_d = (remaining_q != 6'd0) ? StIssue : StDone;
        end else if (timer_q == TimeoutW) begin
          state_d = StFault;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    busy_d   = !(state_d inside {StIdle, StFault});
    done_d   = (state_d == StDone);
    err_d    = (state_d == StDone) && err_pend_d;
    fault_d  = (state_d == StFault);
    strobe_d = (state_d == StWaitHi) ? coin_d : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      credit_q    <= 6'd0;
      remaining_q <= 6'd0;
      coin_q      <= 3'b000;
      timer_q     <= 8'd0;
      coins_q     <= 3'd0;
      err_pend_q  <= 1'b0;
      strobe_q    <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      timer_q     <= timer_d;
      coins_q     <= coins_d;
      err_pend_q  <= err_pend_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fault_q     <= fault_d;
    end
  end

  assign eject20_o   = strobe_q[2];
  assign eject10_o   = strobe_q[1];
  assign eject5_o    = strobe_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign fault_o     = fault_q;
  assign coins_out_o = coins_q;

endmodule
